// File: rtl/bitwise_ram_engine_if.sv
// Command/response bundle for bitwise_ram_engine: the controller drives commands
// and operands, and the engine returns registered status and result data.
interface bitwise_ram_engine_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              start;
    logic [2:0]        cmd;
    logic [1:0]        operation;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addrEnd;
    logic [DATA_W-1:0] dataIn;
    logic [DATA_W-1:0] maskIn;
    logic [DATA_W-1:0] dataOut;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output start, cmd, operation, addr, addrEnd, dataIn, maskIn,
        input  dataOut, busy, done, err
    );

    modport slave (
        input  start, cmd, operation, addr, addrEnd, dataIn, maskIn,
        output dataOut, busy, done, err
    );
endinterface

// File: rtl/bitwise_ram_engine.sv
// Register-file RAM with bitwise write, read, read-modify-write, wrapping range
// sweep and full clear, sequenced through a start/busy/done handshake.
module bitwise_ram_engine #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    bitwise_ram_engine_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;
    localparam logic [2:0] CMD_RMW   = 3'b010;
    localparam logic [2:0] CMD_SWEEP = 3'b011;
    localparam logic [2:0] CMD_CLEAR = 3'b100;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        S_RMW   = 2'd1,
        S_SWEEP = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    function automatic logic [DATA_W-1:0] apply_op(
        input logic [1:0]        op,
        input logic [DATA_W-1:0] x,
        input logic [DATA_W-1:0] m
    );
        logic [DATA_W-1:0] r;
        case (op)
            2'b00:   r = x & m;
            2'b01:   r = x | m;
            2'b10:   r = x ^ m;
            2'b11:   r = ~(x & m);
            default: r = '0;
        endcase
        return r;
    endfunction

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [DATA_W-1:0] rd_q, rd_d;
    logic [1:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] end_q, end_d;
    logic [DATA_W-1:0] mask_q, mask_d;

    // Power-up contents are zero; reset deliberately leaves the array alone.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    logic              we_s;
    logic [ADDR_W-1:0] waddr_s;
    logic [DATA_W-1:0] wdata_s;
    logic [DATA_W-1:0] write_val_s;
    logic [DATA_W-1:0] rmw_res_s;
    logic [DATA_W-1:0] sweep_res_s;

    // Next-state, write-port and output decode for the command FSM.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        dout_d      = dout_q;
        ptr_d       = ptr_q;
        rd_d        = rd_q;
        op_d        = op_q;
        addr_d      = addr_q;
        end_d       = end_q;
        mask_d      = mask_q;
        we_s        = 1'b0;
        waddr_s     = ptr_q;
        wdata_s     = '0;
        write_val_s = apply_op(bus.operation, bus.dataIn, bus.maskIn);
        rmw_res_s   = apply_op(op_q, rd_q, mask_q);
        sweep_res_s = apply_op(op_q, mem_q[ptr_q], mask_q);

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (bus.start) begin
                    op_d   = bus.operation;
                    addr_d = bus.addr;
                    end_d  = bus.addrEnd;
                    mask_d = bus.maskIn;
                    case (bus.cmd)
                        CMD_WRITE: begin
                            we_s    = 1'b1;
                            waddr_s = bus.addr;
                            wdata_s = write_val_s;
                            dout_d  = write_val_s;
                            done_d  = 1'b1;
                        end
                        CMD_READ: begin
                            dout_d = mem_q[bus.addr];
                            done_d = 1'b1;
                        end
                        CMD_RMW: begin
                            rd_d    = mem_q[bus.addr];
                            busy_d  = 1'b1;
                            state_d = S_RMW;
                        end
                        CMD_SWEEP: begin
                            ptr_d   = bus.addr;
                            busy_d  = 1'b1;
                            state_d = S_SWEEP;
                        end
                        CMD_CLEAR: begin
                            ptr_d   = '0;
                            busy_d  = 1'b1;
                            state_d = S_CLEAR;
                        end
                        default: begin
                            err_d  = 1'b1;
                            done_d = 1'b1;
                        end
                    endcase
                end else begin
                    state_d = IDLE;
                end
            end
            S_RMW: begin
                we_s    = 1'b1;
                waddr_s = addr_q;
                wdata_s = rmw_res_s;
                dout_d  = rmw_res_s;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            S_SWEEP: begin
                we_s    = 1'b1;
                waddr_s = ptr_q;
                wdata_s = sweep_res_s;
                dout_d  = sweep_res_s;
                // The pointer width makes the increment wrap modulo DEPTH.
                if (ptr_q == end_q) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    ptr_d = ptr_q + ADDR_ONE;
                end
            end
            S_CLEAR: begin
                we_s    = 1'b1;
                waddr_s = ptr_q;
                wdata_s = '0;
                if (ptr_q == LAST_ADDR) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    dout_d  = '0;
                    state_d = IDLE;
                end else begin
                    ptr_d = ptr_q + ADDR_ONE;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Control and status registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            dout_q  <= '0;
            ptr_q   <= '0;
            rd_q    <= '0;
            op_q    <= 2'b00;
            addr_q  <= '0;
            end_q   <= '0;
            mask_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            dout_q  <= dout_d;
            ptr_q   <= ptr_d;
            rd_q    <= rd_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            end_q   <= end_d;
            mask_q  <= mask_d;
        end
    end

    // Single write port; a reset edge suppresses the write of an aborted command.
    always_ff @(posedge clk_i) begin
        if (!rst_i && we_s) begin
            mem_q[waddr_s] <= wdata_s;
        end
    end

    assign bus.dataOut = dout_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;
endmodule

// File: tb/tb_bitwise_ram_engine.sv
// Directed self-checking bench for bitwise_ram_engine; status is checked as the
// packed vector {busy, done, err, dataOut} sampled 1 time unit after each edge.
module tb_bitwise_ram_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bitwise_ram_engine_if #(.DATA_W(8), .ADDR_W(3)) bus_if ();

    bitwise_ram_engine #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_if)
    );

    wire [10:0] stat = {bus_if.busy, bus_if.done, bus_if.err, bus_if.dataOut};

    localparam logic [2:0] C_WR = 3'b000, C_RD = 3'b001, C_RMW = 3'b010,
                           C_SW = 3'b011, C_CL = 3'b100, C_BAD = 3'b111;
    localparam logic [1:0] O_AND = 2'b00, O_OR = 2'b01, O_XOR = 2'b10, O_NAND = 2'b11;

    task automatic issue(input logic [2:0] c, input logic [1:0] op, input logic [2:0] a,
                         input logic [2:0] e, input logic [7:0] d, input logic [7:0] m);
        @(negedge clk);
        bus_if.start     = 1'b1;
        bus_if.cmd       = c;
        bus_if.operation = op;
        bus_if.addr      = a;
        bus_if.addrEnd   = e;
        bus_if.dataIn    = d;
        bus_if.maskIn    = m;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus_if.start = 1'b0; bus_if.cmd = 3'b000; bus_if.operation = 2'b00;
        bus_if.addr = 3'd0; bus_if.addrEnd = 3'd0; bus_if.dataIn = 8'h00; bus_if.maskIn = 8'h00;
        rst = 1'b1;
        tick(); tick();
        checks++;
        if (stat !== 11'h000) begin
            errors++; $display("FAIL reset_state: got %h expected %h", stat, 11'h000);
        end
        @(negedge clk); rst = 1'b0;
        issue(C_RD, O_AND, 3'd3, 3'd0, 8'h00, 8'h00);
        checks++;
        if (stat !== {3'b010, 8'h00}) begin
            errors++; $display("FAIL powerup_zero: got %h expected %h", stat, {3'b010, 8'h00});
        end
    endtask

    task automatic test_write_read();
        issue(C_WR, O_XOR, 3'd3, 3'd0, 8'hF0, 8'h3C);
        checks++;
        if (stat !== {3'b010, 8'hCC}) begin
            errors++; $display("FAIL write_xor: got %h expected %h", stat, {3'b010, 8'hCC});
        end
        tick();
        checks++;
        if (stat !== {3'b000, 8'hCC}) begin
            errors++; $display("FAIL done_pulse_hold: got %h expected %h", stat, {3'b000, 8'hCC});
        end
        issue(C_RD, O_AND, 3'd3, 3'd0, 8'h00, 8'h00);
        checks++;
        if (stat !== {3'b010, 8'hCC}) begin
            errors++; $display("FAIL read_back3: got %h expected %h", stat, {3'b010, 8'hCC});
        end
    endtask

    task automatic test_rmw();
        issue(C_WR, O_NAND, 3'd0, 3'd0, 8'hFF, 8'hFF);
        checks++;
        if (stat !== {3'b010, 8'h00}) begin
            errors++; $display("FAIL write_nand: got %h expected %h", stat, {3'b010, 8'h00});
        end
        issue(C_RMW, O_AND, 3'd3, 3'd0, 8'h00, 8'h0F);
        checks++;
        if (stat !== {3'b100, 8'h00}) begin
            errors++; $display("FAIL rmw_accept: got %h expected %h", stat, {3'b100, 8'h00});
        end
        @(negedge clk);
        bus_if.maskIn = 8'hFF; bus_if.operation = O_OR; bus_if.addr = 3'd6;
        tick();
        checks++;
        if (stat !== {3'b010, 8'h0C}) begin
            errors++; $display("FAIL rmw_done: got %h expected %h", stat, {3'b010, 8'h0C});
        end
        issue(C_RD, O_AND, 3'd3, 3'd0, 8'h00, 8'h00);
        checks++;
        if (stat !== {3'b010, 8'h0C}) begin
            errors++; $display("FAIL rmw_readback: got %h expected %h", stat, {3'b010, 8'h0C});
        end
    endtask

    task automatic test_clear_sweep();
        int busy_cnt, done_cnt, done_at;
        logic [7:0] exp_mem [8];
        issue(C_CL, O_AND, 3'd0, 3'd0, 8'h00, 8'h00);
        busy_cnt = bus_if.busy ? 1 : 0; done_cnt = 0; done_at = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (bus_if.busy) busy_cnt++;
            if (bus_if.done) begin done_cnt++; done_at = i; end
        end
        checks++;
        if (busy_cnt != 8 || done_cnt != 1 || done_at != 8 || bus_if.dataOut !== 8'h00) begin
            errors++; $display("FAIL clear_timing: got busy=%0d done=%0d at=%0d dout=%h expected 8 1 8 00",
                               busy_cnt, done_cnt, done_at, bus_if.dataOut);
        end
        issue(C_SW, O_OR, 3'd6, 3'd1, 8'h00, 8'h01);
        busy_cnt = bus_if.busy ? 1 : 0; done_cnt = 0; done_at = 0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (bus_if.busy) busy_cnt++;
            if (bus_if.done) begin done_cnt++; done_at = i; end
        end
        checks++;
        if (busy_cnt != 4 || done_cnt != 1 || done_at != 4 || bus_if.dataOut !== 8'h01) begin
            errors++; $display("FAIL sweep_wrap_timing: got busy=%0d done=%0d at=%0d dout=%h expected 4 1 4 01",
                               busy_cnt, done_cnt, done_at, bus_if.dataOut);
        end
        exp_mem[0] = 8'h01; exp_mem[1] = 8'h01; exp_mem[2] = 8'h00; exp_mem[3] = 8'h00;
        exp_mem[4] = 8'h00; exp_mem[5] = 8'h00; exp_mem[6] = 8'h01; exp_mem[7] = 8'h01;
        for (int a = 0; a < 8; a++) begin
            issue(C_RD, O_AND, 3'(a), 3'd0, 8'h00, 8'h00);
            checks++;
            if (bus_if.dataOut !== exp_mem[a]) begin
                errors++; $display("FAIL sweep_mem[%0d]: got %h expected %h", a, bus_if.dataOut, exp_mem[a]);
            end
        end
    endtask

    task automatic test_busy_ignore();
        issue(C_SW, O_XOR, 3'd2, 3'd3, 8'h00, 8'hFF);
        checks++;
        if (stat !== {3'b100, 8'h01}) begin
            errors++; $display("FAIL ignore_accept: got %h expected %h", stat, {3'b100, 8'h01});
        end
        @(negedge clk);
        bus_if.start = 1'b1; bus_if.cmd = C_RD; bus_if.addr = 3'd6;
        tick();
        bus_if.start = 1'b0;
        checks++;
        if (stat !== {3'b100, 8'hFF}) begin
            errors++; $display("FAIL ignore_mid: got %h expected %h", stat, {3'b100, 8'hFF});
        end
        tick();
        checks++;
        if (stat !== {3'b010, 8'hFF}) begin
            errors++; $display("FAIL ignore_done: got %h expected %h", stat, {3'b010, 8'hFF});
        end
        tick();
        checks++;
        if (stat !== {3'b000, 8'hFF}) begin
            errors++; $display("FAIL ignore_after: got %h expected %h", stat, {3'b000, 8'hFF});
        end
        issue(C_RD, O_AND, 3'd3, 3'd0, 8'h00, 8'h00);
        checks++;
        if (bus_if.dataOut !== 8'hFF) begin
            errors++; $display("FAIL ignore_mem3: got %h expected %h", bus_if.dataOut, 8'hFF);
        end
    endtask

    task automatic test_reset_abort();
        int done_cnt;
        logic [7:0] exp_mem [4];
        issue(C_CL, O_AND, 3'd0, 3'd0, 8'h00, 8'h00);
        done_cnt = 0;
        for (int i = 0; i < 12 && done_cnt == 0; i++) begin
            tick();
            if (bus_if.done) done_cnt++;
        end
        checks++;
        if (done_cnt != 1) begin
            errors++; $display("FAIL abort_clear_timeout: got done=%0d expected 1", done_cnt);
        end
        issue(C_SW, O_OR, 3'd2, 3'd5, 8'h00, 8'hAA);
        tick();
        checks++;
        if (stat !== {3'b100, 8'hAA}) begin
            errors++; $display("FAIL abort_first_edge: got %h expected %h", stat, {3'b100, 8'hAA});
        end
        @(negedge clk); rst = 1'b1;
        tick();
        checks++;
        if (stat !== 11'h000) begin
            errors++; $display("FAIL abort_reset_state: got %h expected %h", stat, 11'h000);
        end
        @(negedge clk); rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (bus_if.done || bus_if.busy) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", done_cnt);
        end
        exp_mem[0] = 8'hAA; exp_mem[1] = 8'h00; exp_mem[2] = 8'h00; exp_mem[3] = 8'h00;
        for (int a = 0; a < 4; a++) begin
            issue(C_RD, O_AND, 3'(a + 2), 3'd0, 8'h00, 8'h00);
            checks++;
            if (bus_if.dataOut !== exp_mem[a]) begin
                errors++; $display("FAIL abort_mem[%0d]: got %h expected %h", a + 2, bus_if.dataOut, exp_mem[a]);
            end
        end
    endtask

    task automatic test_illegal();
        logic [7:0] exp_mem [8];
        issue(C_WR, O_OR, 3'd4, 3'd0, 8'h5A, 8'h00);
        checks++;
        if (stat !== {3'b010, 8'h5A}) begin
            errors++; $display("FAIL illegal_setup: got %h expected %h", stat, {3'b010, 8'h5A});
        end
        issue(C_BAD, O_OR, 3'd4, 3'd7, 8'hFF, 8'hFF);
        checks++;
        if (stat !== {3'b011, 8'h5A}) begin
            errors++; $display("FAIL illegal_pulse: got %h expected %h", stat, {3'b011, 8'h5A});
        end
        tick();
        checks++;
        if (stat !== {3'b000, 8'h5A}) begin
            errors++; $display("FAIL illegal_one_cycle: got %h expected %h", stat, {3'b000, 8'h5A});
        end
        exp_mem[0] = 8'h00; exp_mem[1] = 8'h00; exp_mem[2] = 8'hAA; exp_mem[3] = 8'h00;
        exp_mem[4] = 8'h5A; exp_mem[5] = 8'h00; exp_mem[6] = 8'h00; exp_mem[7] = 8'h00;
        for (int a = 0; a < 8; a++) begin
            issue(C_RD, O_AND, 3'(a), 3'd0, 8'h00, 8'h00);
            checks++;
            if (bus_if.dataOut !== exp_mem[a]) begin
                errors++; $display("FAIL illegal_mem[%0d]: got %h expected %h", a, bus_if.dataOut, exp_mem[a]);
            end
        end
    endtask

    task automatic test_back_to_back();
        issue(C_WR, O_AND, 3'd1, 3'd0, 8'h12, 8'hFF);
        checks++;
        if (stat !== {3'b010, 8'h12}) begin
            errors++; $display("FAIL b2b_wr1: got %h expected %h", stat, {3'b010, 8'h12});
        end
        issue(C_WR, O_XOR, 3'd5, 3'd0, 8'h0F, 8'hF0);
        checks++;
        if (stat !== {3'b010, 8'hFF}) begin
            errors++; $display("FAIL b2b_wr5: got %h expected %h", stat, {3'b010, 8'hFF});
        end
        issue(C_RD, O_AND, 3'd1, 3'd0, 8'h00, 8'h00);
        checks++;
        if (stat !== {3'b010, 8'h12}) begin
            errors++; $display("FAIL b2b_rd1: got %h expected %h", stat, {3'b010, 8'h12});
        end
        issue(C_RD, O_AND, 3'd5, 3'd0, 8'h00, 8'h00);
        checks++;
        if (stat !== {3'b010, 8'hFF}) begin
            errors++; $display("FAIL b2b_rd5: got %h expected %h", stat, {3'b010, 8'hFF});
        end
        issue(C_SW, O_AND, 3'd5, 3'd5, 8'h00, 8'h0F);
        checks++;
        if (stat !== {3'b100, 8'hFF}) begin
            errors++; $display("FAIL single_sweep_accept: got %h expected %h", stat, {3'b100, 8'hFF});
        end
        tick();
        checks++;
        if (stat !== {3'b010, 8'h0F}) begin
            errors++; $display("FAIL single_sweep_done: got %h expected %h", stat, {3'b010, 8'h0F});
        end
        issue(C_RD, O_AND, 3'd6, 3'd0, 8'h00, 8'h00);
        checks++;
        if (bus_if.dataOut !== 8'h00) begin
            errors++; $display("FAIL single_sweep_mem6: got %h expected %h", bus_if.dataOut, 8'h00);
        end
        issue(C_RD, O_AND, 3'd5, 3'd0, 8'h00, 8'h00);
        checks++;
        if (bus_if.dataOut !== 8'h0F) begin
            errors++; $display("FAIL single_sweep_mem5: got %h expected %h", bus_if.dataOut, 8'h0F);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_rmw();
        test_clear_sweep();
        test_busy_ignore();
        test_reset_abort();
        test_illegal();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
